// File: rtl/svif_stim_sequencer.sv
// rtl/svif_stim_sequencer.sv - two-pass stimulus sweep with MISR response compaction
module svif_stim_sequencer #(
  parameter int          SIG_W      = 2,
  parameter int          OTHER_W    = 22,
  parameter int          PASS_W     = 16,
  parameter int          STEPS      = 20,
  parameter int          PASSES     = 2,
  parameter int          RST_CYCLES = 2,
  parameter logic [31:0] POLY       = 32'h04C1_1DB7,
  parameter logic [31:0] SEED       = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               dut_rst,
  output logic [SIG_W-1:0]   dut_sig,
  output logic               dut_flip,
  output logic               dut_setting,
  input  logic [OTHER_W-1:0] dut_out_other,
  input  logic [SIG_W-1:0]   dut_sig_out,
  input  logic [PASS_W-1:0]  dut_pass_through,
  input  logic [SIG_W-1:0]   dut_if_sig_out,
  output logic [31:0]        signature,
  output logic [23:0]        sample_count
);

  localparam int         SAMPLE_W  = OTHER_W + PASS_W + 2 * SIG_W;
  localparam int         NSLICE    = (SAMPLE_W + 31) / 32;
  localparam int         PAD_W     = NSLICE * 32;
  localparam logic [7:0]  RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [15:0] STEP_LAST = 16'(STEPS - 1);
  localparam logic [7:0]  PASS_LAST = 8'(PASSES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    SETTLE = 3'd2,
    DRIVE  = 3'd3,
    DONE   = 3'd4
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic [7:0]        rstCnt;
  logic [15:0]       stepIdx;
  logic [7:0]        passIdx;
  logic [15:0]       stepNext;
  logic [7:0]        passNext;
  logic              lastStep;
  logic              lastPass;
  logic [SAMPLE_W-1:0] sample;
  logic [PAD_W-1:0]  samplePad;
  logic [31:0]       foldVal;
  logic [31:0]       misrNext;

  // The interface setting input is never exercised by this sweep.
  assign dut_setting = 1'b0;

  assign sample    = {dut_out_other, dut_sig_out, dut_pass_through, dut_if_sig_out};
  assign samplePad = PAD_W'(sample);

  assign lastStep  = (stepIdx == STEP_LAST);
  assign lastPass  = (passIdx == PASS_LAST);
  assign stepNext  = lastStep ? 16'd0 : stepIdx + 16'd1;
  assign passNext  = lastStep ? passIdx + 8'd1 : passIdx;

  // Fold the sample down to 32 bits by XOR of 32-bit slices; top slice is zero-padded.
  always_comb begin
    foldVal = '0;
    for (int k = 0; k < NSLICE; k++) begin
      foldVal = foldVal ^ samplePad[k*32 +: 32];
    end
  end

  assign misrNext = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ foldVal;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode; start is only honoured when no run is in flight.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: if (start) stateNext = RESET;
      RESET:      if (rstCnt == RST_LAST) stateNext = SETTLE;
      SETTLE:     stateNext = DRIVE;
      DRIVE:      if (lastStep && lastPass) stateNext = DONE;
      default:    stateNext = IDLE;
    endcase
  end

  // Registered stimulus, status, counters and MISR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      dut_rst      <= 1'b1;
      dut_sig      <= '0;
      dut_flip     <= 1'b0;
      signature    <= '0;
      sample_count <= '0;
      rstCnt       <= '0;
      stepIdx      <= '0;
      passIdx      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done         <= 1'b0;
            busy         <= 1'b1;
            dut_rst      <= 1'b1;
            dut_sig      <= '0;
            dut_flip     <= 1'b0;
            signature    <= SEED;
            sample_count <= '0;
            rstCnt       <= '0;
            stepIdx      <= '0;
            passIdx      <= '0;
          end else if (state == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        RESET: begin
          rstCnt <= rstCnt + 8'd1;
          if (rstCnt == RST_LAST) begin
            dut_rst <= 1'b0;
          end
        end
        SETTLE: begin
          dut_sig  <= '0;
          dut_flip <= 1'b0;
        end
        DRIVE: begin
          signature    <= misrNext;
          sample_count <= sample_count + 24'd1;
          stepIdx      <= stepNext;
          passIdx      <= passNext;
          // The final stimulus is left in place once the sweep ends.
          if (!(lastStep && lastPass)) begin
            dut_sig  <= SIG_W'(stepNext);
            dut_flip <= passNext[0];
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
